// File: rtl/lsu_arbiter.sv
// Purpose: shares the single LSU data/MMIO port between the memory stage and a DMA/debug requester.
// Latency: core accesses add 0 cycles; DMA ready is combinational; DMA read data is returned 1 cycle after the handshake.
// Backpressure: the core is held with core_stall_o while DMA owns the port; DMA is held off via dma_ready_o.
// Optional feature: define LSU_ARB_STARVE_GUARD_EN to force a starved DMA request through after MAX_WAIT refusals.
`timescale 1ns/1ps

module lsu_arbiter #(
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    // memory-stage side
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [9:0]  core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        core_stall_o,
    // DMA/debug side
    input  logic        dma_valid_i,
    input  logic        dma_we_i,
    input  logic [9:0]  dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_ready_o,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_rdata_o,
    // lsu side
    output logic [9:0]  lsu_addr_o,
    output logic [31:0] lsu_st_data_o,
    output logic        lsu_st_en_o,
    input  logic [31:0] lsu_ld_data_i
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

    typedef enum logic {
        S_CORE = 1'b0,
        S_DMA  = 1'b1
    } state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic          dma_gnt;
    logic          core_gnt;
    logic          force_dma;
    logic          dma_rd_gnt;

`ifdef LSU_ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    logic [WW-1:0] wait_cnt;

    // A request refused MAX_WAIT times in a row wins over the core next time.
    assign force_dma = (wait_cnt == WAIT_LIMIT);

    // Count consecutive refused cycles of a pending DMA request; a grant or a withdrawn request restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (dma_gnt || !dma_valid_i) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end
`else
    // Strict core priority: an idle core cycle is the only way in for DMA.
    assign force_dma = 1'b0;

    // MAX_WAIT has no effect in this build; the empty block only keeps the parameter referenced.
    if (MAX_WAIT < 1) begin : g_max_wait_unused
    end
`endif

    // Grant decision: core first, DMA on idle core cycles, when starved, or while its burst allowance lasts.
    always_comb begin
        dma_gnt = 1'b0;
        if (state == S_DMA) begin
            dma_gnt = dma_valid_i & (!core_req_i | (beat_cnt < BURST_LIMIT));
        end else begin
            dma_gnt = dma_valid_i & (!core_req_i | force_dma);
        end
    end

    assign core_gnt   = core_req_i & !dma_gnt;
    assign dma_rd_gnt = dma_gnt & !dma_we_i;

    // Handshake and stall are forced low while reset is asserted so no store can slip out.
    assign dma_ready_o  = rst & dma_gnt;
    assign core_stall_o = rst & core_req_i & !core_gnt;

    // Port mux: the DMA drives the LSU only when granted; otherwise the core inputs pass straight through.
    assign lsu_addr_o    = dma_gnt ? dma_addr_i  : core_addr_i;
    assign lsu_st_data_o = dma_gnt ? dma_wdata_i : core_wdata_i;
    assign lsu_st_en_o   = rst & (dma_gnt ? dma_we_i : (core_gnt & core_we_i));

    // Load data is a pure pass-through; the memory-stage register samples it.
    assign core_rdata_o = lsu_ld_data_i;

    // Ownership FSM: enter/stay in S_DMA on every DMA grant, counting beats; any non-grant cycle hands back to the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_CORE;
            beat_cnt <= '0;
        end else if (dma_gnt) begin
            state <= S_DMA;
            if (state == S_CORE) begin
                beat_cnt <= BW'(1);
            end else if (beat_cnt != BURST_LIMIT) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end else begin
            state    <= S_CORE;
            beat_cnt <= '0;
        end
    end

    // DMA read return: capture load data at the handshake edge and pulse rvalid for one cycle; stores return nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rvalid_o <= 1'b0;
            dma_rdata_o  <= '0;
        end else begin
            dma_rvalid_o <= dma_rd_gnt;
            if (dma_rd_gnt) begin
                dma_rdata_o <= lsu_ld_data_i;
            end
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Purpose: directed + randomized checking of lsu_arbiter against a rule-level reference model.
// Latency: combinational outputs sampled at the falling edge, registered outputs 1 time unit after the rising edge.
// Backpressure: DMA requests are held stable until granted, with occasional legal withdrawals.
`timescale 1ns/1ps

module tb_lsu_arbiter;

    localparam int MAX_WAIT  = 8;
    localparam int MAX_BURST = 4;
`ifdef LSU_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [9:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        core_stall;
    logic        dma_valid, dma_we;
    logic [9:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ready, dma_rvalid;
    logic [31:0] dma_rdata;
    logic [9:0]  lsu_addr;
    logic [31:0] lsu_st_data;
    logic        lsu_st_en;
    logic [31:0] lsu_ld_data;

    lsu_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_rdata_o (core_rdata),
        .core_stall_o (core_stall),
        .dma_valid_i  (dma_valid),
        .dma_we_i     (dma_we),
        .dma_addr_i   (dma_addr),
        .dma_wdata_i  (dma_wdata),
        .dma_ready_o  (dma_ready),
        .dma_rvalid_o (dma_rvalid),
        .dma_rdata_o  (dma_rdata),
        .lsu_addr_o   (lsu_addr),
        .lsu_st_data_o(lsu_st_data),
        .lsu_st_en_o  (lsu_st_en),
        .lsu_ld_data_i(lsu_ld_data)
    );

    always #5 clk = ~clk;

    // Environment memory standing in for the lsu instance.
    logic [31:0] mem [0:1023];
    assign lsu_ld_data = mem[lsu_addr];
    always @(posedge clk) if (lsu_st_en) mem[lsu_addr] <= lsu_st_data;

    int checks = 0;
    int errors = 0;

    // Reference model: streak of refused DMA cycles, beats in the current DMA burst, expected memory.
    int          m_streak;
    int          m_burst;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    logic [31:0] ref_mem [0:1023];

    bit          e_dgnt, e_cgnt, e_sten, e_stall;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    bit          obs_ready, obs_stall;

    bit rdy_rec   [1:24];
    bit stall_rec [1:24];
    int first_gnt, run_len, next_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_streak = 0;
        m_burst  = 0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
    endtask

    task automatic model_comb();
        bit allow;
        if (m_burst > 0) allow = (m_burst < MAX_BURST);
        else             allow = GUARD && (m_streak >= MAX_WAIT);
        e_dgnt  = rst && dma_valid && (!core_req || allow);
        e_cgnt  = rst && core_req && !e_dgnt;
        e_stall = rst && core_req && e_dgnt;
        e_sten  = e_dgnt ? dma_we : (e_cgnt && core_we);
        e_addr  = e_dgnt ? dma_addr : core_addr;
        e_data  = e_dgnt ? dma_wdata : core_wdata;
    endtask

    task automatic check_comb();
        model_comb();
        obs_ready = dma_ready;
        obs_stall = core_stall;
        chk("dma_ready", dma_ready, e_dgnt);
        chk("core_stall", core_stall, e_stall);
        chk("lsu_st_en", lsu_st_en, e_sten);
        chk("lsu_addr", lsu_addr, e_addr);
        chk("lsu_st_data", lsu_st_data, e_data);
        if (e_cgnt && !core_we) chk("core_rdata", core_rdata, ref_mem[core_addr]);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        if (e_dgnt && !dma_we) m_rdata = ref_mem[dma_addr];
        m_rvalid = e_dgnt && !dma_we;
        if (e_sten) ref_mem[e_addr] = e_data;
        if (e_dgnt || !dma_valid) m_streak = 0;
        else                      m_streak++;
        m_burst = e_dgnt ? m_burst + 1 : 0;
        #1;
        chk("dma_rvalid", dma_rvalid, m_rvalid);
        chk("dma_rdata", dma_rdata, m_rdata);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_comb();
        end_cycle();
    endtask

    task automatic set_core(input bit req, input bit we, input logic [9:0] a, input logic [31:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_dma(input bit v, input bit we, input logic [9:0] a, input logic [31:0] d);
        dma_valid = v; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        logic [31:0] v;
        bit busy;
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        model_reset();

        // Reset with every request active: handshake, stall and store enable must stay low.
        set_core(1'b1, 1'b1, 10'h3ff, 32'h1234_5678);
        set_dma(1'b1, 1'b1, 10'h3fe, 32'h8765_4321);
        #1 rst = 1'b0;
        #2;
        chk("reset_st_en", lsu_st_en, 1'b0);
        chk("reset_ready", dma_ready, 1'b0);
        chk("reset_stall", core_stall, 1'b0);
        chk("reset_rvalid", dma_rvalid, 1'b0);
        chk("reset_rdata", dma_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Core store then load, DMA idle.
        set_dma(1'b0, 1'b0, 10'h0, 32'h0);
        set_core(1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF);
        @(negedge clk);
        check_comb();
        chk("core_store_st_en", lsu_st_en, 1'b1);
        chk("core_store_stall", core_stall, 1'b0);
        end_cycle();
        set_core(1'b1, 1'b0, 10'h010, 32'h0);
        @(negedge clk);
        check_comb();
        chk("core_load_data", core_rdata, 32'hDEAD_BEEF);
        end_cycle();

        // DMA read while the core is idle.
        set_core(1'b0, 1'b0, 10'h0, 32'h0);
        set_dma(1'b1, 1'b0, 10'h010, 32'h0);
        @(negedge clk);
        check_comb();
        chk("dma_idle_ready", dma_ready, 1'b1);
        end_cycle();
        chk("dma_idle_rvalid", dma_rvalid, 1'b1);
        chk("dma_idle_rdata", dma_rdata, 32'hDEAD_BEEF);
        set_dma(1'b0, 1'b0, 10'h0, 32'h0);
        cycle();

        // Continuous core loads against a held DMA write.
        set_core(1'b1, 1'b0, 10'h010, 32'h0);
        set_dma(1'b1, 1'b1, 10'h020, 32'hA5A5_0001);
        for (int i = 1; i <= 24; i++) begin
            cycle();
            rdy_rec[i]   = obs_ready;
            stall_rec[i] = obs_stall;
        end
        first_gnt = 0; run_len = 0; next_gnt = 0;
        for (int i = 1; i <= 24; i++) if (rdy_rec[i] && first_gnt == 0) first_gnt = i;
        if (first_gnt != 0) begin
            for (int i = first_gnt; i <= 24; i++) begin
                if (!rdy_rec[i]) break;
                run_len++;
            end
            for (int i = first_gnt + run_len; i <= 24; i++) if (rdy_rec[i] && next_gnt == 0) next_gnt = i;
        end
        chk("starve_first_grant", first_gnt, GUARD ? 9 : 0);
        chk("starve_burst_len", run_len, GUARD ? MAX_BURST : 0);
        chk("starve_next_grant", next_gnt, GUARD ? 21 : 0);
        chk("starve_refused_c8", rdy_rec[8], 1'b0);
        chk("starve_stall_c12", stall_rec[12], GUARD ? 1'b1 : 1'b0);
        chk("starve_stall_c13", stall_rec[13], 1'b0);

        // Core goes idle: the waiting DMA is granted in that same cycle.
        set_core(1'b0, 1'b0, 10'h0, 32'h0);
        @(negedge clk);
        check_comb();
        chk("core_idle_dma_gnt", dma_ready, 1'b1);
        end_cycle();
        set_dma(1'b0, 1'b0, 10'h0, 32'h0);
        cycle();

        // Reset during the second beat of a DMA read burst.
        set_dma(1'b1, 1'b0, 10'h020, 32'h0);
        cycle();
        @(negedge clk);
        check_comb();
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_rvalid", dma_rvalid, 1'b0);
        chk("midrst_rdata", dma_rdata, 32'h0);
        chk("midrst_ready", dma_ready, 1'b0);
        chk("midrst_st_en", lsu_st_en, 1'b0);
        #1 rst = 1'b1;
        set_core(1'b1, 1'b0, 10'h020, 32'h0);
        set_dma(1'b1, 1'b0, 10'h020, 32'h0);
        #1;
        check_comb();
        chk("postrst_core_first", core_stall, 1'b0);
        chk("postrst_dma_wait", dma_ready, 1'b0);
        end_cycle();

        // Randomized traffic: heavy core load first, then mixed.
        for (int n = 0; n < 600; n++) begin
            busy = (n < 300) ? ($urandom_range(7, 0) != 0) : ($urandom_range(1, 0) == 1);
            set_core(busy, 1'($urandom_range(1, 0)), 10'($urandom_range(15, 0)), $urandom);
            if (dma_valid && !e_dgnt) begin
                if ($urandom_range(15, 0) == 0) dma_valid = 1'b0;
            end else begin
                set_dma(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                        10'($urandom_range(15, 0)), $urandom);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Shares the single data-memory/MMIO port (`lsu`) between the pipeline memory stage and a DMA/debug requester. Core accesses have priority and complete in one cycle with no stall. A DMA requester gets the port on idle core cycles, or after a bounded wait, for a bounded burst. While the DMA owns the port, the arbiter raises a stall that freezes the IF/ID/EX/MEM pipeline registers. Sits between the memory stage and the `lsu` instance; the memory-stage pipeline register still samples `core_rdata_o`.

## Interface
Parameters:
- `MAX_WAIT`, default 8: cycles a pending DMA request may be refused before it is forced through (≥1).
- `MAX_BURST`, default 4: consecutive DMA beats allowed while the core is requesting (≥1).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `core_req_i` in 1: memory stage has a load or store this cycle.
- `core_we_i` in 1: 1 = store.
- `core_addr_i` in 10: byte address (ALU result [9:0]).
- `core_wdata_i` in 32: store data.
- `core_rdata_o` out 32: load data; combinational pass-through of `lsu_ld_data_i`.
- `core_stall_o` out 1: hold the pipeline; the memory-stage access repeats next cycle.
- `dma_valid_i` in 1: DMA request valid.
- `dma_we_i` in 1: DMA store.
- `dma_addr_i` in 10: DMA address.
- `dma_wdata_i` in 32: DMA store data.
- `dma_ready_o` out 1: DMA granted this cycle; the transfer occurs on the clock edge where `dma_valid_i & dma_ready_o`.
- `dma_rvalid_o` out 1: one-cycle pulse; `dma_rdata_o` is valid.
- `dma_rdata_o` out 32: registered DMA load data.
- `lsu_addr_o` out 10: to `lsu` addr.
- `lsu_st_data_o` out 32: to `lsu` st_data.
- `lsu_st_en_o` out 1: to `lsu` st_en.
- `lsu_ld_data_i` in 32: from `lsu` ld_data; combinational read.

## Operation
- **FSM states:** S_CORE (reset state) and S_DMA.
- **Counters:**
  - `wait_cnt`: 0..MAX_WAIT, saturating.
  - `beat_cnt`: 0..MAX_BURST, saturating.
  - Width of each is $clog2(MAX+1).
- **Grant decision** (combinational, from state, requests and counters):
  - In S_CORE, DMA is granted if `dma_valid_i & (!core_req_i | wait_cnt==MAX_WAIT)`. Otherwise the core is granted if `core_req_i`.
  - In S_DMA, DMA is granted if `dma_valid_i & (!core_req_i | beat_cnt<MAX_BURST)`. Otherwise the core is granted.
- **Transitions:**
  - S_CORE→S_DMA on a DMA grant; `beat_cnt`←1.
  - S_DMA stays in S_DMA on a DMA grant; `beat_cnt`++.
  - S_DMA→S_CORE on a cycle without a DMA grant; `beat_cnt`←0.
- **`wait_cnt` update:**
  - Increments on cycles with `dma_valid_i & !dma_ready_o`.
  - Clears on a DMA grant or when `dma_valid_i`=0.
- **LSU mux:**
  - The granted requester drives `lsu_addr_o` and `lsu_st_data_o`.
  - `lsu_st_en_o` = granted requester's we & grant.
  - With no grant: `lsu_st_en_o`=0 and address/data = core inputs.
- **Stall:** `core_stall_o` = `core_req_i & !core grant`.
- **DMA read:** on a granted DMA read, `dma_rdata_o`←`lsu_ld_data_i` at the edge, and `dma_rvalid_o` pulses 1 in the following cycle. A DMA store produces no rvalid.
- **DMA request stability:** DMA must hold valid, we, addr and wdata stable until ready. Dropping valid before ready is legal; the request is withdrawn and the counters are cleared.
- **Simultaneous requests:** exactly one requester touches the LSU per cycle; a store is never issued twice.

## Timing
- **Reset values:**
  - state=S_CORE, `wait_cnt`=0, `beat_cnt`=0.
  - `dma_rvalid_o`=0, `dma_rdata_o`=0.
  - While `rst`=0: `lsu_st_en_o`=0, `dma_ready_o`=0, `core_stall_o`=0 (forced regardless of inputs).
- **Core:** zero added latency. Load data is valid in the request cycle; a store commits at the edge ending the grant cycle.
- **DMA:** `dma_ready_o` is combinational in the grant cycle. Read data arrives 1 cycle after the handshake edge.
- **Worst-case DMA wait** under continuous core traffic: MAX_WAIT refused cycles, granted in cycle MAX_WAIT+1.
- **Worst-case core stall per burst:** MAX_BURST consecutive cycles.
- **Reset mid-burst:** async return to S_CORE; counters cleared and `dma_rvalid_o` deasserted immediately. An in-flight DMA read is lost.

## Configuration
- Macro: `LSU_ARB_STARVE_GUARD_EN`.
- **Defined:** the `wait_cnt` forcing rule above applies.
- **Undefined:**
  - `wait_cnt` is not implemented and `MAX_WAIT` is unused.
  - S_CORE grants DMA only when `!core_req_i` (strict core priority).
  - S_DMA behaviour is unchanged.

## Test plan
- **Reset:** assert `rst`=0 with `core_req_i`=1, `core_we_i`=1, `dma_valid_i`=1 → `lsu_st_en_o`=0, `dma_ready_o`=0, `core_stall_o`=0, `dma_rvalid_o`=0, `dma_rdata_o`=0.
- **Core only:**
  - Store 0xDEADBEEF to 0x010 → `lsu_st_en_o`=1 in the same cycle, `core_stall_o`=0.
  - Next cycle, load 0x010 → `core_rdata_o`=0xDEADBEEF.
- **DMA, core idle:** read 0x010 → `dma_ready_o`=1 in the request cycle; next cycle `dma_rvalid_o`=1 and `dma_rdata_o`=0xDEADBEEF; state returns to S_CORE.
- **Guard defined, core_req held, DMA writes held 20 cycles (defaults):**
  - Refused 8 cycles.
  - Cycles 9–12: `dma_ready_o`=1 and `core_stall_o`=1.
  - Cycle 13: core granted, stall=0.
  - Next DMA grant 8 cycles later.
- **Guard undefined, same stimulus:** `dma_ready_o` stays 0 throughout; on `core_req_i`→0, DMA is granted that cycle.
- **Reset mid-burst:**
  - Drop `rst` during the 2nd DMA beat of a read burst → state S_CORE, `beat_cnt`=0, `dma_rvalid_o`=0 before the next edge.
  - After release, with `core_req_i`=1 and `dma_valid_i`=1, the core is granted first.
